// File: rtl/msr_gpio_pkg.sv
// Shared definitions for the MSR-to-GPIO transmitter: FSM state encoding and sizing helpers.
package msr_gpio_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_REQ      = 3'd1;
    localparam logic [2:0] ST_WAIT_RDY = 3'd2;
    localparam logic [2:0] ST_SETUP    = 3'd3;
    localparam logic [2:0] ST_STRB     = 3'd4;
    localparam logic [2:0] ST_RELEASE  = 3'd5;

    function automatic int unsigned beats_f(input int unsigned data_w, input int unsigned bus_w);
        return data_w / bus_w;
    endfunction

    // Bits needed to hold any value in 0..max_val, never less than one.
    function automatic int unsigned cnt_w_f(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/gpio_sync.sv
// Multi-flop synchroniser for an asynchronous single-bit input, reset to 0.
module gpio_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/msr_gpio_tx.sv
// Fetches words from transfer_msr and sends them to the RPi as MSB-first GPIO beats,
// each beat using a 4-phase strobe/ack handshake with an ack-edge timeout.
module msr_gpio_tx
    import msr_gpio_pkg::*;
#(
    parameter int unsigned DATA_W      = 24,
    parameter int unsigned BUS_W       = 8,
    parameter int unsigned SETUP_CYC   = 2,
    parameter int unsigned ACK_TIMEOUT = 1000000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              ref_clk,
    input  logic              rst_n,
    input  logic              gpio_en_i,
    output logic              data_req_o,
    input  logic              data_rdy_i,
    input  logic [DATA_W-1:0] msr_data_i,
    output logic [BUS_W-1:0]  gpio_data_o,
    output logic              gpio_first_o,
    output logic              gpio_strb_o,
    input  logic              gpio_ack_i,
    output logic              busy_o,
    output logic              err_timeout_o,
    output logic [15:0]       word_cnt_o
);

    localparam int unsigned BEATS  = beats_f(DATA_W, BUS_W);
    localparam int unsigned BEAT_W = cnt_w_f(BEATS - 1);
    localparam int unsigned SET_W  = cnt_w_f(SETUP_CYC);
    localparam int unsigned TO_W   = cnt_w_f(ACK_TIMEOUT);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [SET_W-1:0]  SET_LAST  = SET_W'(SETUP_CYC - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(ACK_TIMEOUT - 1);

    logic en_s;
    logic ack_s;

    logic [2:0]        state_q, state_d;
    logic [DATA_W-1:0] sreg_q, sreg_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [SET_W-1:0]  set_cnt_q, set_cnt_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [BUS_W-1:0]  data_q, data_d;
    logic              first_q, first_d;
    logic              err_q, err_d;
    logic [15:0]       word_cnt_q, word_cnt_d;
    logic              load_beat;

    gpio_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync_en (
        .clk_i (ref_clk),
        .rst_n (rst_n),
        .d_i   (gpio_en_i),
        .q_o   (en_s)
    );

    gpio_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync_ack (
        .clk_i (ref_clk),
        .rst_n (rst_n),
        .d_i   (gpio_ack_i),
        .q_o   (ack_s)
    );

    always_comb begin
        state_d    = state_q;
        sreg_d     = sreg_q;
        beat_d     = beat_q;
        set_cnt_d  = set_cnt_q;
        to_cnt_d   = to_cnt_q;
        data_d     = data_q;
        first_d    = first_q;
        err_d      = err_q;
        word_cnt_d = word_cnt_q;
        load_beat  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (en_s && !err_q) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                state_d = ST_WAIT_RDY;
            end
            ST_WAIT_RDY: begin
                if (data_rdy_i) begin
                    sreg_d    = msr_data_i;
                    beat_d    = '0;
                    load_beat = 1'b1;
                    state_d   = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (set_cnt_q == SET_LAST) begin
                    to_cnt_d = '0;
                    state_d  = ST_STRB;
                end else begin
                    set_cnt_d = set_cnt_q + 1'b1;
                end
            end
            ST_STRB: begin
                // An ack seen on the final allowed cycle still wins over the timeout.
                if (ack_s) begin
                    to_cnt_d = '0;
                    state_d  = ST_RELEASE;
                end else if (to_cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            ST_RELEASE: begin
                if (!ack_s) begin
                    if (beat_q != LAST_BEAT) begin
                        sreg_d    = sreg_q << BUS_W;
                        beat_d    = beat_q + 1'b1;
                        load_beat = 1'b1;
                        state_d   = ST_SETUP;
                    end else begin
                        word_cnt_d = word_cnt_q + 16'd1;
                        state_d    = ST_IDLE;
                    end
                end else if (to_cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Beat outputs are captured on entry to SETUP and held through STRB/RELEASE.
        if (load_beat) begin
            set_cnt_d = '0;
            data_d    = sreg_d[DATA_W-1 -: BUS_W];
            first_d   = (beat_d == '0);
        end else if (state_d == ST_IDLE) begin
            data_d  = '0;
            first_d = 1'b0;
        end
    end

    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            sreg_q     <= '0;
            beat_q     <= '0;
            set_cnt_q  <= '0;
            to_cnt_q   <= '0;
            data_q     <= '0;
            first_q    <= 1'b0;
            err_q      <= 1'b0;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            sreg_q     <= sreg_d;
            beat_q     <= beat_d;
            set_cnt_q  <= set_cnt_d;
            to_cnt_q   <= to_cnt_d;
            data_q     <= data_d;
            first_q    <= first_d;
            err_q      <= err_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    assign data_req_o    = (state_q == ST_REQ);
    assign gpio_strb_o   = (state_q == ST_STRB);
    assign busy_o        = (state_q != ST_IDLE);
    assign gpio_data_o   = data_q;
    assign gpio_first_o  = first_q;
    assign err_timeout_o = err_q;
    assign word_cnt_o    = word_cnt_q;

endmodule
